// File: rtl/buffer_drain_scheduler_pkg.sv
// Shared definitions for the buffer drain scheduler.
// Holds the frame-sequencer state encoding, the default header tag and
// small sizing helpers used by the top level and the arbiter.
package buffer_drain_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    HDR  = 3'd3,
    DATA = 3'd4
  } state_t;

  localparam logic [3:0] HDR_TAG_DEFAULT   = 4'hA;
  localparam int         WORD_BITS_DEFAULT = 32;
  localparam int         BYTES_PER_WORD    = WORD_BITS_DEFAULT / 8;

  // Number of bytes carried by one buffer word.
  function automatic int bytes_per_word(input int word_bits);
    return word_bits / 8;
  endfunction

  // Index width for n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buffer_drain_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or above ptr, searching upward
// modulo NUM_CH.
// Ports:
//   req       in  NUM_CH  request vector
//   ptr       in  PTR_W   search start index
//   gnt_idx   out PTR_W   granted index (0 when nothing is granted)
//   gnt_valid out 1       at least one request present
module rr_arbiter
  import buffer_drain_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  // Scan from the farthest offset down to ptr so the nearest requester wins.
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    idx_s     = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_s     = PTR_W'((int'(ptr) + k) % NUM_CH);
      gnt_idx   = req[idx_s] ? idx_s : gnt_idx;
      gnt_valid = gnt_valid | req[idx_s];
    end
  end

endmodule

// File: rtl/buffer_drain_scheduler.sv
// Round-robin drain scheduler sharing one byte transmitter between
// NUM_CH sample buffers. Buffer occupancy is mirrored from the write
// strobes; each served word goes out as a header byte followed by the
// word's bytes, most significant first.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   enable     allows new frames to start
//   ch_wr      per-buffer write strobes (copy of wr_enable)
//   ch_rd_en   one-hot single-cycle read strobe to the buffers
//   ch_data    concatenated buffer outputs, channel i at [i*W +: W]
//   tx_data/tx_valid/tx_ready  byte stream to the transmitter
//   busy       sequencer not idle
//   ovf        sticky per-channel write-while-full flag
//   frame_cnt  completed frames, wrapping
module buffer_drain_scheduler
  import buffer_drain_scheduler_pkg::*;
#(
  parameter int         NUM_CH               = 4,
  parameter int         BUFFER_LENGTH        = 4,
  parameter int         CNT_BITS             = 5,
  parameter int         VARIABLE_LENGTH_BITS = WORD_BITS_DEFAULT,
  parameter logic [3:0] HDR_TAG              = HDR_TAG_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NUM_CH-1:0]                    ch_wr,
  output logic [NUM_CH-1:0]                    ch_rd_en,
  input  logic [NUM_CH*VARIABLE_LENGTH_BITS-1:0] ch_data,
  output logic [7:0]                           tx_data,
  output logic                                 tx_valid,
  input  logic                                 tx_ready,
  output logic                                 busy,
  output logic [NUM_CH-1:0]                    ovf,
  output logic [15:0]                          frame_cnt
);

  localparam int W     = VARIABLE_LENGTH_BITS;
  localparam int BYTES = bytes_per_word(W);
  localparam int PTR_W = idx_width(NUM_CH);
  localparam int BI_W  = idx_width(BYTES);

  localparam logic [CNT_BITS-1:0] CNT_FULL  = CNT_BITS'(BUFFER_LENGTH);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [PTR_W-1:0]    LAST_CH   = PTR_W'(NUM_CH - 1);
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [BI_W-1:0]     LAST_BYTE = BI_W'(BYTES - 1);
  localparam logic [BI_W-1:0]     BI_ONE    = BI_W'(1);

  state_t            state_r;
  logic [PTR_W-1:0]  ch_sel_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [W-1:0]      word_r;
  logic [BI_W-1:0]   byte_idx_r;

  logic [NUM_CH-1:0] req_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic              gnt_valid_s;
  logic [NUM_CH-1:0] gnt_onehot_s;
  logic [PTR_W-1:0]  rr_next_s;
  logic [W-1:0]      sel_word_s;
  logic [BI_W-1:0]   byte_sel_s;
  logic [7:0]        next_byte_s;
  logic [3:0]        ch_sel_nib_s;

  // Occupancy mirrors: a simultaneous write and read cancel; a write to a
  // full mirror is what the buffer drops, so it only raises ovf.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt_r;
    logic                ovf_r;

    // Per-channel occupancy counter and sticky overflow flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r <= '0;
        ovf_r <= 1'b0;
      end else if (ch_wr[i] && ch_rd_en[i]) begin
        cnt_r <= cnt_r;
      end else if (ch_wr[i]) begin
        if (cnt_r < CNT_FULL) cnt_r <= cnt_r + CNT_ONE;
        else                  ovf_r <= 1'b1;
      end else if (ch_rd_en[i] && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end

    assign req_s[i] = (cnt_r != '0);
    assign ovf[i]   = ovf_r;
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req       (req_s),
    .ptr       (rr_ptr_r),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  assign rr_next_s    = (gnt_idx_s == LAST_CH) ? '0 : gnt_idx_s + PTR_ONE;
  assign ch_sel_nib_s = 4'(ch_sel_r);
  // In HDR the next byte is the top one; in DATA it is one below the current.
  assign byte_sel_s   = (state_r == HDR) ? LAST_BYTE : byte_idx_r - BI_ONE;

  // Grant decode, selected channel word and next outgoing data byte.
  always_comb begin
    gnt_onehot_s = '0;
    sel_word_s   = '0;
    next_byte_s  = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_onehot_s[i] = (gnt_idx_s == PTR_W'(i));
      sel_word_s      = (ch_sel_r == PTR_W'(i)) ? ch_data[i*W +: W] : sel_word_s;
    end
    for (int b = 0; b < BYTES; b++) begin
      next_byte_s = (byte_sel_s == BI_W'(b)) ? word_r[b*8 +: 8] : next_byte_s;
    end
  end

  // Frame sequencer; outputs are loaded together with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ch_sel_r   <= '0;
      rr_ptr_r   <= '0;
      word_r     <= '0;
      byte_idx_r <= '0;
      ch_rd_en   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && gnt_valid_s) begin
            state_r  <= READ;
            ch_sel_r <= gnt_idx_s;
            rr_ptr_r <= rr_next_s;
            ch_rd_en <= gnt_onehot_s;
            busy     <= 1'b1;
          end
        end
        READ: begin
          ch_rd_en <= '0;
          state_r  <= CAPT;
        end
        CAPT: begin
          // The buffer registered its output at the end of READ.
          word_r   <= sel_word_s;
          tx_valid <= 1'b1;
          tx_data  <= {HDR_TAG, ch_sel_nib_s};
          state_r  <= HDR;
        end
        HDR: begin
          if (tx_ready) begin
            byte_idx_r <= LAST_BYTE;
            tx_data    <= next_byte_s;
            state_r    <= DATA;
          end
        end
        DATA: begin
          if (tx_ready) begin
            if (byte_idx_r != '0) begin
              byte_idx_r <= byte_idx_r - BI_ONE;
              tx_data    <= next_byte_s;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              tx_valid  <= 1'b0;
              tx_data   <= 8'h00;
              busy      <= 1'b0;
              state_r   <= IDLE;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          ch_rd_en <= '0;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_drain_scheduler.sv
// Self-checking bench for buffer_drain_scheduler. A behavioural model of
// the four data buffers feeds ch_data; every accepted write pushes its
// expected frame bytes into a scoreboard queue, and a monitor pops and
// compares on each tx handshake.
module tb_buffer_drain_scheduler;

  localparam int NCH = 4;
  localparam int BL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [NCH-1:0]  ch_wr;
  logic [NCH-1:0]  ch_rd_en;
  logic [NCH*32-1:0] ch_data;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [NCH-1:0]  ovf;
  logic [15:0]     frame_cnt;

  logic [31:0]     wr_word;
  logic [31:0]     bo [NCH];
  logic [31:0]     bq [NCH][$];
  logic [7:0]      exp_q [$];

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  held_v = 1'b0;
  logic [7:0] held_byte;

  buffer_drain_scheduler #(
    .NUM_CH               (NCH),
    .BUFFER_LENGTH        (BL),
    .CNT_BITS             (5),
    .VARIABLE_LENGTH_BITS (32),
    .HDR_TAG              (4'hA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ch_wr     (ch_wr),
    .ch_rd_en  (ch_rd_en),
    .ch_data   (ch_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .ovf       (ovf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_bo
    assign ch_data[g*32 +: 32] = bo[g];
  end

  initial begin
    for (int i = 0; i < NCH; i++) bo[i] = 32'h0;
  end

  // Buffer model: registered output on rd_enable, drops writes when full.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_rd_en[i] && bq[i].size() != 0) bo[i] <= bq[i].pop_front();
      if (ch_wr[i] && bq[i].size() < BL) bq[i].push_back(wr_word);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on each transfer, stability check while stalled.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (tx_valid && held_v) check("stall_hold", {24'h0, tx_data}, {24'h0, held_byte});
      if (tx_valid && tx_ready) begin
        check("byte_expected", {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        held_v = 1'b0;
      end else if (tx_valid) begin
        held_v    = 1'b1;
        held_byte = tx_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic push_frame(input int ch, input logic [31:0] w);
    logic [3:0] nib;
    nib = 4'(ch);
    exp_q.push_back({4'hA, nib});
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic do_write(input logic [NCH-1:0] mask, input logic [31:0] w);
    for (int i = 0; i < NCH; i++)
      if (mask[i] && bq[i].size() < BL) push_frame(i, w);
    ch_wr   = mask;
    wr_word = w;
    @(posedge clk); #1;
    ch_wr = '0;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      tx_ready = toggle ? ~tx_ready : 1'b1;
      n++;
    end
    check("drain_left", exp_q.size(), 32'h0);
    tx_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("idle_after", {31'h0, busy}, 32'h0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; ch_wr = '0; tx_ready = 1'b0; wr_word = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rd_en", {28'h0, ch_rd_en}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_ovf", {28'h0, ovf}, 32'h0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    rst = 1'b0;

    // Three words on ch2 with the transmitter always ready.
    enable = 1'b1; tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) do_write(4'b0100, 32'h11223344);
    drain(1'b0);
    check("t1_frame_cnt", {16'h0, frame_cnt}, 32'd3);

    // Simultaneous writes on ch0/1/3 from rr_ptr = 0: served in channel order.
    apply_reset();
    do_write(4'b1011, 32'hC0FFEE01);
    drain(1'b0);
    check("t2_frame_cnt", {16'h0, frame_cnt}, 32'd3);

    // Alternating tx_ready stalls.
    do_write(4'b0010, 32'h5566AA99);
    drain(1'b1);
    check("t3_frame_cnt", {16'h0, frame_cnt}, 32'd4);

    // Overfill ch1 while disabled, then release.
    enable = 1'b0;
    for (int k = 0; k < 5; k++) do_write(4'b0010, 32'h10000001 + 32'(k));
    check("t4_ovf", {28'h0, ovf}, 32'h2);
    check("t4_no_start", {31'h0, busy}, 32'h0);
    enable = 1'b1;
    drain(1'b0);
    check("t4_frame_cnt", {16'h0, frame_cnt}, 32'd8);
    check("t4_ovf_sticky", {28'h0, ovf}, 32'h2);

    // Write to ch0 coinciding with its READ cycle (count 2 stays 2).
    enable = 1'b0;
    do_write(4'b0001, 32'hA1A2A3A4);
    do_write(4'b0001, 32'hB1B2B3B4);
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #1;
      if (ch_rd_en != '0) found = 1'b1;
    end
    check("t5_rd_seen", {31'h0, found}, 32'h1);
    check("t5_rd_onehot", {28'h0, ch_rd_en}, 32'h1);
    do_write(4'b0001, 32'hC1C2C3C4);
    drain(1'b0);
    check("t5_frame_cnt", {16'h0, frame_cnt}, 32'd11);

    // Reset during the second data byte of a ch3 frame.
    enable = 1'b0;
    do_write(4'b1000, 32'hDEADBEEF);
    do_write(4'b1000, 32'hDEADBEEF);
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #1;
      if (ch_rd_en != '0) found = 1'b1;
    end
    check("t6_rd_seen", {31'h0, found}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_hdr_valid", {31'h0, tx_valid}, 32'h1);
    check("t6_hdr_byte", {24'h0, tx_data}, 32'hA3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_byte2", {24'h0, tx_data}, 32'hAD);
    rst = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("t6_ovf", {28'h0, ovf}, 32'h0);
    check("t6_rd_en", {28'h0, ch_rd_en}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_cnt_cleared", {31'h0, busy}, 32'h0);
    check("t6_no_frames", {16'h0, frame_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buffer_drain_scheduler.md
Name: buffer_drain_scheduler

Overview:
- Round-robin scheduler that shares one byte-wide comm transmitter between NUM_CH dataBuffer instances.
- Mirrors each buffer's occupancy from its write strobes, because the buffers export no full/empty flags.
- Issues single-cycle rd_enable pulses, captures the registered buf_out word and serialises it as a framed byte stream: header byte, then data bytes MSB first.
- Sits between the per-channel sample buffers and the UART/SPI byte transmitter.

Parameters:
- NUM_CH, 4: number of buffers served; 1..16.
- BUFFER_LENGTH, 4: depth of each served buffer; sets the occupancy saturation limit.
- CNT_BITS, 5: width of each occupancy counter; must hold BUFFER_LENGTH.
- VARIABLE_LENGTH_BITS, 32: buffer word width; multiple of 8.
- HDR_TAG, 4'hA: upper nibble of the header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits new frames to start; does not abort a frame in progress.
- ch_wr  in  NUM_CH  copy of each buffer's wr_enable.
- ch_rd_en  out  NUM_CH  rd_enable to each buffer; one-hot, single-cycle.
- ch_data  in  NUM_CH*VARIABLE_LENGTH_BITS  concatenated buf_out; channel i occupies bits [i*W +: W].
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  high in any state other than IDLE.
- ovf  out  NUM_CH  sticky flag: a write arrived while the mirrored count was full.
- frame_cnt  out  16  number of completed frames; wraps.

Behaviour:
- Reset, synchronous: state = IDLE, all counters = 0, rr_ptr = 0.
  - Outputs: ch_rd_en = 0, tx_valid = 0, tx_data = 0, busy = 0, ovf = 0, frame_cnt = 0.
- Occupancy counter cnt[i], updated every cycle:
  - +1 on ch_wr[i] when cnt < BUFFER_LENGTH.
  - −1 on ch_rd_en[i].
  - Both events in the same cycle: unchanged.
  - ch_wr[i] while cnt == BUFFER_LENGTH (and no read that cycle): cnt holds and ovf[i] is set. This matches the buffer dropping the write.
- Arbitration, evaluated in IDLE when enable = 1:
  - Request vector is cnt[i] != 0.
  - Grant goes to the first requester at or after rr_ptr, searching upward modulo NUM_CH.
  - On grant, rr_ptr <= granted index + 1, wrapping NUM_CH−1 → 0.
  - No requesters, or enable = 0: stay in IDLE.
- State machine:
  - IDLE → READ on grant; the granted index is latched in ch_sel.
  - READ, 1 cycle: ch_rd_en[ch_sel] = 1 and cnt decrements. → CAPT.
  - CAPT, 1 cycle: the buffer output registered at the previous edge; word_reg <= ch_data slice of ch_sel. → HDR.
  - HDR: tx_valid = 1, tx_data = {HDR_TAG, ch_sel[3:0]}. Hold until tx_ready. → DATA with byte_idx = VARIABLE_LENGTH_BITS/8 − 1.
  - DATA: tx_valid = 1, tx_data = word_reg[byte_idx*8 +: 8].
    - On tx_ready with byte_idx > 0: decrement byte_idx.
    - On tx_ready with byte_idx = 0: frame_cnt++ → IDLE.
- Handshake:
  - A byte transfers on a cycle with tx_valid & tx_ready.
  - tx_data stays stable while tx_valid = 1 and tx_ready = 0.
  - tx_valid deasserts in IDLE, READ and CAPT.
- Latency:
  - Grant to first header-byte presentation: 3 cycles.
  - A frame with tx_ready held high: 4 + W/8 cycles, IDLE back to IDLE (W = VARIABLE_LENGTH_BITS).
  - The next grant is evaluated in the following IDLE cycle.
- Boundary conditions:
  - A write to the channel being read during READ nets to zero change in cnt.
  - Writes to any channel continue to be counted during HDR/DATA.
  - enable falling mid-frame: the frame completes.
  - rst mid-frame: immediate return to the reset state; partial frame dropped.
  - NUM_CH = 1: rr_ptr stays 0.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE, READ, CAPT, HDR, DATA;
  - HDR_TAG default;
  - helper constant BYTES_PER_WORD = VARIABLE_LENGTH_BITS/8.
- One natural sub-module: rr_arbiter.
  - Ports: req[NUM_CH] and ptr in; gnt_idx and gnt_valid out.
  - Purely combinational; instantiated once.
- Occupancy counters generated inline with a generate loop.

Test Plan:
- Reset, then 3 writes to ch2 with data 0x11223344, tx_ready = 1 → stream A2 11 22 33 44 (repeated for the 3 buffered words), then frame_cnt = 3, cnt[2] = 0, busy = 0.
- One write each to ch0, ch1, ch3 in the same cycle, rr_ptr = 0 → frames in channel order 0, 1, 3; headers A0, A1, A3.
- tx_ready toggling 1-0-1-0 during DATA → tx_data holds each byte while stalled; no byte skipped or duplicated; 5 transfers per frame.
- 5 writes to ch1 with BUFFER_LENGTH = 4, enable = 0 → cnt[1] = 4, ovf[1] = 1. Raise enable → exactly 4 frames.
- ch_wr[0] coincident with ch_rd_en[0] during READ, cnt = 2 → cnt stays 2 after READ.
- rst asserted during the second DATA byte → next cycle tx_valid = 0, busy = 0, all counters 0, frame_cnt = 0.
